// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - md_op_e    : operation encodings driven on the op port
//   - md_state_e : sequencer states (IDLE -> CALC -> FIX -> IDLE)
//   - MD_WIDTH   : default operand/result width
package muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architecturally visible HI/LO.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on operand magnitudes; signs are applied once in the FIX state.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start, op, a, b  operation request (sampled only in IDLE)
//   hiwrite, lowrite direct HI/LO load from wd (honoured only in IDLE)
//   wd               direct write data
//   busy             operation in progress (decoded from state)
//   done             one-cycle pulse, new HI/LO valid
//   div_by_zero      valid with done; divide with b == 0
//   hi, lo           result registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hiwrite,
  input  logic             lowrite,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             div_op;
  logic             neg_q;   // quotient / product must be negated
  logic             neg_r;   // remainder takes the dividend's sign
  logic             dbz;

  // Working registers: for multiply acc_hi:acc_lo is the shifting product
  // with the multiplier consumed from acc_lo[0]; for divide acc_hi is the
  // partial remainder and acc_lo shifts the dividend out and quotient in.
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;

  logic             op_signed;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH-1:0] u;
    u = v;
    return (is_signed && u[WIDTH-1]) ? -u : u;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign busy      = (state != IDLE);

  // ---- iteration step ----
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // When div_ge holds the true difference is below opnd, so the
    // modular WIDTH-bit subtraction is exact.
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (div_op) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // ---- sign correction ----
  // Divide by zero naturally leaves |a| in the remainder, so the signed
  // remainder equals the original a; only the quotient needs forcing.
  always_comb begin
    prod = cond_neg2({acc_hi, acc_lo}, neg_q);
    if (div_op) begin
      res_hi = cond_neg(acc_hi, neg_r);
      res_lo = dbz ? '1 : cond_neg(acc_lo, neg_q);
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // ---- control and HI/LO ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      div_op      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hiwrite) hi <= wd;
          if (lowrite) lo <= wd;
          if (start) begin
            state  <= CALC;
            cnt    <= CNT_W'(WIDTH - 1);
            div_op <= (op == MD_DIV) || (op == MD_DIVU);
            neg_q  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= op_signed & a[WIDTH-1];
            dbz    <= ((op == MD_DIV) || (op == MD_DIVU)) && (b == '0);
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          hi          <= res_hi;
          lo          <= res_lo;
          done        <= 1'b1;
          div_by_zero <= dbz;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- working datapath (no reset needed; always loaded on start) ----
  // Multiply is commutative, so both families load a into acc_lo and b
  // into opnd.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      acc_hi <= '0;
      acc_lo <= magnitude(a, op_signed);
      opnd   <= magnitude(b, op_signed);
    end else if (state == CALC) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): directed operations with hand-computed
// results pushed to a scoreboard; a monitor pops an entry on every done.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        hiwrite, lowrite;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   busy_cnt = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hiwrite(hiwrite), .lowrite(lowrite), .wd(wd),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // Advance to the next falling edge and drop one-shot requests.
  task automatic step();
    @(negedge clk);
    start   = 1'b0;
    hiwrite = 1'b0;
    lowrite = 1'b0;
    if (busy === 1'b1) busy_cnt++;
  endtask

  // Called at a falling edge: drives the request for the next rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input bit track, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed);
    op = o; a = av; b = bv; start = 1'b1;
    if (track) sb.push_back('{hi: eh, lo: el, dbz: ed, cyc: cyc});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < 100);
    check("done_within_budget", 64'(done === 1'b1), 64'd1);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && done === 1'b1) begin
        check("done_expected", 64'(sb.size() != 0), 64'd1);
        check("busy_low_in_done", 64'(busy), 64'd0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("hi", 64'(hi), 64'(e.hi));
          check("lo", 64'(lo), 64'(e.lo));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          check("latency", 64'(cyc - e.cyc), 64'd34);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hiwrite = 1'b0; lowrite = 1'b0; wd = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    // Direct HI/LO writes in IDLE
    hiwrite = 1'b1; wd = 32'hCAFEF00D; step();
    check("mthi", 64'(hi), 64'hCAFEF00D);
    lowrite = 1'b1; wd = 32'h12345678; step();
    check("mtlo", 64'(lo), 64'h12345678);

    // Signed multiply, with an ignored mtlo while busy
    busy_cnt = 0;
    issue(MD_MULT, 32'hFFFFFFFF, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0);
    repeat (3) step();
    lowrite = 1'b1; wd = 32'h11111111; step();
    check("lo_hold_while_busy", 64'(lo), 64'h12345678);
    wait_done();
    check("mult_busy_cycles", 64'(busy_cnt), 64'd33);

    // Back-to-back: start in the done cycle
    issue(MD_MULTU, 32'hFFFFFFFF, 32'd5, 1, 32'h00000004, 32'hFFFFFFFB, 1'b0);
    wait_done();

    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done();
    step();
    issue(MD_DIV, 32'd100, 32'hFFFFFFF9, 1, 32'h00000002, 32'hFFFFFFF2, 1'b0);
    wait_done();
    step();
    issue(MD_MULT, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 1'b0);
    wait_done();
    step();

    // Start pulse while busy must be ignored
    issue(MD_DIVU, 32'd7, 32'd2, 1, 32'd1, 32'd3, 1'b0);
    repeat (5) step();
    op = MD_MULT; a = 32'h100; b = 32'h100; start = 1'b1;
    step();
    wait_done();
    repeat (40) step();
    check("ignored_start_hi", 64'(hi), 64'd1);
    check("ignored_start_lo", 64'(lo), 64'd3);

    // Divide by zero and signed overflow
    issue(MD_DIVU, 32'h1234, 32'd0, 1, 32'h00001234, 32'hFFFFFFFF, 1'b1);
    wait_done();
    step();
    check("dbz_one_cycle", 64'(div_by_zero), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    issue(MD_DIV, 32'hFFFFFFF0, 32'd0, 1, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
    wait_done();
    step();
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 1'b0);
    wait_done();
    step();

    // mthi in the same cycle as start; result overwrites it at FIX
    issue(MD_MULTU, 32'd3, 32'd4, 1, 32'h00000000, 32'h0000000C, 1'b0);
    hiwrite = 1'b1; wd = 32'hA5A5A5A5;
    step();
    check("mthi_with_start", 64'(hi), 64'hA5A5A5A5);
    wait_done();
    step();

    // Reset in the middle of a multiply
    issue(MD_MULT, 32'd7, 32'd9, 0, 32'd0, 32'd0, 1'b0);
    repeat (10) step();
    #2 reset = 1'b1;
    #1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    repeat (3) step();
    reset = 1'b0;
    repeat (40) step();

    issue(MD_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0);
    wait_done();
    step();

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers, attached beside the ALU in the multicycle datapath. It executes signed and unsigned multiply and divide over WIDTH-bit operands using one shift-add or shift-subtract step per cycle. It reports progress through a start/busy/done handshake, which the main controller FSM waits on. HI/LO are architecturally visible and directly writable for mthi/mtlo.

## Interface
- WIDTH, 32, operand and result width; must be at least 4.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- hiwrite  in  1  load HI from wd (mthi).
- lowrite  in  1  load LO from wd (mtlo).
- wd  in  WIDTH  HI/LO direct write data.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle pulse; the new HI/LO are valid in this cycle.
- div_by_zero  out  1  valid with done; high when a div/divu had b == 0.
- hi  out  WIDTH  HI register: upper product half, or remainder.
- lo  out  WIDTH  LO register: lower product half, or quotient.

## Operation
- States:
  - IDLE: start=1 → CALC. Latch op; latch |a| and |b| for signed ops, raw values otherwise. Latch the result signs. Load the iteration counter with WIDTH-1.
  - CALC: one step per cycle. Decrement the counter; on counter==0 → FIX.
    - mult/multu: shift-add into a 2·WIDTH-bit accumulator.
    - div/divu: restoring shift-subtract, producing remainder and quotient.
  - FIX: apply sign correction, write HI/LO, → IDLE.
- Arithmetic:
  - mult: {hi,lo} = signed 2·WIDTH-bit product.
  - multu: {hi,lo} = unsigned 2·WIDTH-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (div or divu): lo = all ones, hi = a (original value), div_by_zero=1.
  - Signed overflow (div of most-negative by −1): lo = most-negative, hi = 0, div_by_zero=0.
- start while busy is ignored; no queueing.
- hiwrite/lowrite are honoured only in IDLE and ignored while busy.
  - In IDLE they update HI/LO at the next edge.
  - If start is asserted in the same cycle, the write still takes effect, and the result overwrites it at FIX.
- HI/LO hold their value between operations. Intermediate CALC values never appear on hi/lo.
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE.
- Reset mid-operation abandons the operation immediately. No partial result is written.

## Timing
- start sampled at edge E0.
  - busy is high from E0 through the FIX cycle: WIDTH+1 cycles.
  - hi/lo are updated at the edge ending FIX, which is edge E0+WIDTH+1.
  - done and div_by_zero are high for the one cycle following that edge.
- Latency from the start edge to done is WIDTH+2 cycles (34 for WIDTH=32).
- busy=0 while done=1. A new start may be sampled in the done cycle, giving back-to-back operations.
- done is registered.
- busy is decoded from state, without a combinational path from start.

## Structure
- Shared package holds:
  - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - state encodings: IDLE, CALC, FIX.
  - the default WIDTH constant.
- Single module; no sub-module is needed. HI/LO may reuse the existing enabled-register primitive with asynchronous reset.
- The iteration counter width is $clog2(WIDTH).

## Test plan
- mult a=0xFFFFFFFF, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFFB; done exactly 34 cycles after the start edge; busy high for 33 cycles.
- multu a=0xFFFFFFFF, b=5 → hi=0x00000004, lo=0xFFFFFFFB. Back-to-back: start in the done cycle; the second operation completes 34 cycles later.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1, div_by_zero=0.
- divu a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 for one cycle. div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Reset asserted in the 10th cycle of a mult → hi=lo=0, busy=done=0 immediately. A start pulse during busy is ignored (hi/lo unchanged, no extra done).
- IDLE with hiwrite=1, wd=0xCAFEF00D → hi=0xCAFEF00D next cycle. lowrite while busy → lo unchanged until FIX writes the result.
